// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the hazard-detection inputs and the stall/flush/freeze controls
// exchanged between the 5-stage pipeline and the central hazard sequencer.
//   master : the hazard sequencer (drives PCWrite/IF-ID/NoOp/freeze/err/stats)
//   slave  : the pipeline datapath (drives load/branch/dmem status)
// Signals:
//   IDEX_MemRead_i, IDEX_rd_i      load in EX and its destination register
//   IFID_rs1_i, IFID_rs2_i         source registers of the instruction in ID
//   branch_taken_i                 branch in ID resolved taken this cycle
//   dmem_req_i, dmem_ready_i       data-memory access request / completion
//   PCWrite_o, IFID_stall_o, IFID_flush_o, NoOp_o, freeze_o, err_o
//   stall_cnt_o, flush_cnt_o       saturating statistics counters (CNT_W)
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_rd_i;
    logic [4:0]       IFID_rs1_i;
    logic [4:0]       IFID_rs2_i;
    logic             branch_taken_i;
    logic             dmem_req_i;
    logic             dmem_ready_i;
    logic             PCWrite_o;
    logic             IFID_stall_o;
    logic             IFID_flush_o;
    logic             NoOp_o;
    logic             freeze_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        input  IDEX_MemRead_i, IDEX_rd_i, IFID_rs1_i, IFID_rs2_i,
               branch_taken_i, dmem_req_i, dmem_ready_i,
        output PCWrite_o, IFID_stall_o, IFID_flush_o, NoOp_o, freeze_o,
               err_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        output IDEX_MemRead_i, IDEX_rd_i, IFID_rs1_i, IFID_rs2_i,
               branch_taken_i, dmem_req_i, dmem_ready_i,
        input  PCWrite_o, IFID_stall_o, IFID_flush_o, NoOp_o, freeze_o,
               err_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline, sitting beside ID.
// Combines load-use detection, taken-branch flush and a memory-wait FSM with
// timeout into PCWrite, IF/ID hold/flush, the ID/EX bubble and a global
// freeze. Also keeps saturating stall/flush statistics counters.
// Parameters:
//   MEM_TIMEOUT  max consecutive frozen memory-wait cycles before ERROR (>=2)
//   CNT_W        width of the statistics counters
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous, active-low reset
//   bus     pipeline_hazard_ctrl_if.master (hazard inputs, control outputs)
// All control outputs are combinational from the FSM state and the inputs.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    pipeline_hazard_ctrl_if.master bus
);

    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERROR    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic load_use;
    logic mem_miss;
    logic pc_write;
    logic ifid_stall;
    logic ifid_flush;
    logic noop;
    logic freeze;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = bus.IDEX_MemRead_i && (bus.IDEX_rd_i != 5'd0) &&
                      ((bus.IDEX_rd_i == bus.IFID_rs1_i) ||
                       (bus.IDEX_rd_i == bus.IFID_rs2_i));
    assign mem_miss = bus.dmem_req_i && !bus.dmem_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_INIT;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pc_write   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        noop       = 1'b0;
        freeze     = 1'b0;
        unique case (state_q)
            S_INIT: begin
                ifid_stall = 1'b1;
                noop       = 1'b1;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (mem_miss) begin
                    // The miss cycle is the first frozen cycle of the wait.
                    freeze     = 1'b1;
                    ifid_stall = 1'b1;
                    state_d    = S_MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end else if (load_use) begin
                    // A branch in ID is dropped here; it re-resolves after the bubble.
                    ifid_stall = 1'b1;
                    noop       = 1'b1;
                end else if (bus.branch_taken_i) begin
                    ifid_flush = 1'b1;
                    pc_write   = 1'b1;
                end else begin
                    pc_write   = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                // Freeze holds through the ready cycle; the pipeline moves on the next one.
                freeze     = 1'b1;
                ifid_stall = 1'b1;
                if (bus.dmem_ready_i) begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
                    state_d    = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            S_ERROR: begin
                freeze     = 1'b1;
                ifid_stall = 1'b1;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // INIT is excluded from the stall statistic even though PC is held there.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write && (state_q != S_INIT))
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if (ifid_flush)
                flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign bus.PCWrite_o    = pc_write;
    assign bus.IFID_stall_o = ifid_stall;
    assign bus.IFID_flush_o = ifid_flush;
    assign bus.NoOp_o       = noop;
    assign bus.freeze_o     = freeze;
    assign bus.err_o        = (state_q == S_ERROR);
    assign bus.stall_cnt_o  = stall_cnt_q;
    assign bus.flush_cnt_o  = flush_cnt_q;

endmodule
